cache_mem_arb: RTL and testbench
================================

// Module: cache_mem_arb
// PURPOSE
//  Arbitrates the I-cache fill port and the D-cache fill/writeback port onto the single
//  shared main-memory port. One transaction at a time; fixed, non-pipelined memory latency.
//  Sits between the two cache controllers and the memory inside proc_hier.
//  D side has priority; a streak limit guarantees I-side forward progress.
// PARAMETERS
//  MEM_LAT       4   cycles from the mem_rd/mem_wr cycle to mem_rdata valid (>=1)
//  MAX_D_STREAK  2   max consecutive D grants while i_req is pending (>=1)
//  AW            16  address width
//  DW            16  data width
// PORTS
//  clk        in   1   clock; all state updates on posedge
//  rst        in   1   synchronous, active-low reset (0 = reset)
//  i_req      in   1   I-side read request; held with i_addr until i_done
//  i_addr     in   AW  I-side read address
//  i_done     out  1   one-cycle pulse: I read complete, i_rdata valid
//  i_rdata    out  DW  I-side read data, registered
//  d_req      in   1   D-side request; held with d_wr/d_addr/d_wdata until d_done
//  d_wr       in   1   1 = write, 0 = read
//  d_addr     in   AW  D-side address
//  d_wdata    in   DW  D-side write data
//  d_done     out  1   one-cycle pulse: D transaction complete
//  d_rdata    out  DW  D-side read data, registered
//  mem_rd     out  1   memory read command, exactly one cycle per read
//  mem_wr     out  1   memory write command, exactly one cycle per write
//  mem_addr   out  AW  memory address; stable from ISSUE through DONE
//  mem_wdata  out  DW  memory write data; stable from ISSUE through DONE
//  mem_rdata  in   DW  memory read data; valid exactly MEM_LAT cycles after mem_rd
//  busy       out  1   1 whenever state != IDLE
//  owner      out  1   0 = I, 1 = D; current or last grant
// BEHAVIOUR
//  Reset (rst==0 at posedge): state=IDLE, all outputs 0, lat_cnt=0, streak=0.
//   Any in-flight transaction is abandoned: no done pulse, no data capture.
//  FSM: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
//  IDLE: sample requests (cycle t). If any is pending, latch grant, address, wdata and
//   d_wr into mem_* registers, then go to ISSUE.
//  ISSUE (t+1): mem_rd or mem_wr = 1 for this cycle only. lat_cnt = 1. Go to WAIT.
//  WAIT: lat_cnt increments each cycle. In cycle t+1+MEM_LAT, reads capture mem_rdata
//   into the owner's rdata register; go to DONE. When MEM_LAT==1, WAIT lasts one cycle.
//  DONE (t+MEM_LAT+2): owner's done = 1 for one cycle, then go to IDLE.
//  Total latency from req sampled to done = MEM_LAT+2 cycles.
//   Back-to-back grant period = MEM_LAT+3 cycles.
//  Writes: d_rdata is left unchanged. The non-owner's rdata is never modified.
//  Requester must drop req the cycle after done, unless it is issuing a new request.
//   Req/addr changes while busy are ignored; the latched values are used.
//  Arbitration in IDLE:
//   - Only one of i_req/d_req high: grant it.
//   - Both high: grant D, unless streak==MAX_D_STREAK, in which case grant I.
//  streak update: +1 on a D grant while i_req is high; cleared on an I grant, or on a
//   D grant with i_req low. Saturates at MAX_D_STREAK.
//  lat_cnt width is $clog2(MEM_LAT+1). No wrap is possible.
//  mem_addr/mem_wdata hold their last values in IDLE.
//   mem_rd and mem_wr are never high together.
// TESTING  (MEM_LAT=4, MAX_D_STREAK=2 unless noted)
//  1. rst=0 for 2 cycles with i_req=d_req=1 -> all outputs 0, no mem command.
//     After release, first mem_rd has owner=1.
//  2. i_req, i_addr=0x0040 sampled at cycle t; mem_rdata=0xBEEF at t+5
//     -> mem_rd=1 only at t+1, mem_addr=0x0040; i_done=1 at t+6, i_rdata=0xBEEF.
//  3. D write: d_addr=0x1000, d_wdata=0x1234 -> mem_wr=1 for one cycle, mem_wdata=0x1234;
//     d_done at t+6; d_rdata unchanged.
//  4. i_req and d_req held continuously (re-requesting after each done)
//     -> grant order D,D,I,D,D,I; no grant is ever lost.
//  5. rst=0 during WAIT of a D read -> next cycle busy=0, no d_done.
//     After release with d_req still high, full transaction replays, done 6 cycles later.
//  6. MEM_LAT=1 build: I read sampled at t -> mem_rd at t+1, data captured at t+2,
//     i_done at t+3.

Source files
------------

// File: rtl/cache_mem_arb.sv
// Shares one non-pipelined main-memory port between the I-cache fill path and the D-cache
// fill/writeback path. D side wins ties, bounded by a streak limit so I always progresses.
module cache_mem_arb #(
   parameter int MEM_LAT      = 4,
   parameter int MAX_D_STREAK = 2,
   parameter int AW           = 16,
   parameter int DW           = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   output logic          i_done,
   output logic [DW-1:0] i_rdata,
   input  logic          d_req,
   input  logic          d_wr,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_done,
   output logic [DW-1:0] d_rdata,
   output logic          mem_rd,
   output logic          mem_wr,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy,
   output logic          owner
);

   localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT + 1) : 1;
   localparam int SW = (MAX_D_STREAK > 1) ? $clog2(MAX_D_STREAK + 1) : 1;
   localparam logic [LW-1:0] LAT_LAST   = LW'(MEM_LAT);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE
   } state_t;

   state_t        state_q;
   logic [LW-1:0] latCnt_q;
   logic [SW-1:0] streak_q;
   logic [SW-1:0] streak_d;
   logic          owner_q;
   logic          isWr_q;
   logic          memRd_q;
   logic          memWr_q;
   logic [AW-1:0] memAddr_q;
   logic [DW-1:0] memWdata_q;
   logic          iDone_q;
   logic          dDone_q;
   logic [DW-1:0] iRdata_q;
   logic [DW-1:0] dRdata_q;
   logic          anyReq;
   logic          grantD;

   // A pending I request only overrides D once D has used up its streak allowance.
   assign anyReq = i_req | d_req;
   assign grantD = d_req & ~(i_req & (streak_q == STREAK_MAX));

   always_comb begin
      streak_d = '0;
      if (grantD && i_req) begin
         if (streak_q == STREAK_MAX) begin
            streak_d = streak_q;
         end else begin
            streak_d = streak_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         latCnt_q   <= '0;
         streak_q   <= '0;
         owner_q    <= 1'b0;
         isWr_q     <= 1'b0;
         memRd_q    <= 1'b0;
         memWr_q    <= 1'b0;
         memAddr_q  <= '0;
         memWdata_q <= '0;
         iDone_q    <= 1'b0;
         dDone_q    <= 1'b0;
         iRdata_q   <= '0;
         dRdata_q   <= '0;
      end else begin
         memRd_q <= 1'b0;
         memWr_q <= 1'b0;
         iDone_q <= 1'b0;
         dDone_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (anyReq) begin
                  owner_q   <= grantD;
                  isWr_q    <= grantD & d_wr;
                  memAddr_q <= grantD ? d_addr : i_addr;
                  streak_q  <= streak_d;
                  if (grantD) begin
                     memWdata_q <= d_wdata;
                  end
                  if (grantD && d_wr) begin
                     memWr_q <= 1'b1;
                  end else begin
                     memRd_q <= 1'b1;
                  end
                  state_q <= ISSUE;
               end
            end
            ISSUE: begin
               latCnt_q <= LW'(1);
               state_q  <= WAIT;
            end
            // latCnt_q equals the number of cycles since the memory command was issued.
            WAIT: begin
               if (latCnt_q == LAT_LAST) begin
                  if (!isWr_q) begin
                     if (owner_q) begin
                        dRdata_q <= mem_rdata;
                     end else begin
                        iRdata_q <= mem_rdata;
                     end
                  end
                  if (owner_q) begin
                     dDone_q <= 1'b1;
                  end else begin
                     iDone_q <= 1'b1;
                  end
                  latCnt_q <= '0;
                  state_q  <= DONE;
               end else begin
                  latCnt_q <= latCnt_q + 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign i_done    = iDone_q;
   assign i_rdata   = iRdata_q;
   assign d_done    = dDone_q;
   assign d_rdata   = dRdata_q;
   assign mem_rd    = memRd_q;
   assign mem_wr    = memWr_q;
   assign mem_addr  = memAddr_q;
   assign mem_wdata = memWdata_q;
   assign busy      = (state_q != IDLE);
   assign owner     = owner_q;

endmodule

// File: tb/tb_cache_mem_arb.sv
// Directed bench for cache_mem_arb: a MEM_LAT=4 instance for the main sequence and a
// MEM_LAT=1 instance for the short-latency build. Memory returns addr ^ 16'hBEAF.
module tb_cache_mem_arb;

   logic        clk = 1'b0;
   logic        rst = 1'b0;

   logic        iReq = 1'b0;
   logic [15:0] iAddr = '0;
   logic        iDone;
   logic [15:0] iRdata;
   logic        dReq = 1'b0;
   logic        dWr = 1'b0;
   logic [15:0] dAddr = '0;
   logic [15:0] dWdata = '0;
   logic        dDone;
   logic [15:0] dRdata;
   logic        memRd;
   logic        memWr;
   logic [15:0] memAddr;
   logic [15:0] memWdata;
   logic [15:0] memRdata = 16'hDEAD;
   logic        busy;
   logic        owner;

   logic        bIReq = 1'b0;
   logic [15:0] bIAddr = '0;
   logic        bIDone;
   logic [15:0] bIRdata;
   logic        bDReq = 1'b0;
   logic        bDWr = 1'b0;
   logic [15:0] bDAddr = '0;
   logic [15:0] bDWdata = '0;
   logic        bDDone;
   logic [15:0] bDRdata;
   logic        bMemRd;
   logic        bMemWr;
   logic [15:0] bMemAddr;
   logic [15:0] bMemWdata;
   logic [15:0] bMemRdata = 16'hDEAD;
   logic        bBusy;
   logic        bOwner;

   int vectors = 0;
   int miscompares = 0;

   cache_mem_arb #(.MEM_LAT(4), .MAX_D_STREAK(2), .AW(16), .DW(16)) dut (
      .clk(clk), .rst(rst),
      .i_req(iReq), .i_addr(iAddr), .i_done(iDone), .i_rdata(iRdata),
      .d_req(dReq), .d_wr(dWr), .d_addr(dAddr), .d_wdata(dWdata),
      .d_done(dDone), .d_rdata(dRdata),
      .mem_rd(memRd), .mem_wr(memWr), .mem_addr(memAddr), .mem_wdata(memWdata),
      .mem_rdata(memRdata), .busy(busy), .owner(owner)
   );

   cache_mem_arb #(.MEM_LAT(1), .MAX_D_STREAK(2), .AW(16), .DW(16)) dutLat1 (
      .clk(clk), .rst(rst),
      .i_req(bIReq), .i_addr(bIAddr), .i_done(bIDone), .i_rdata(bIRdata),
      .d_req(bDReq), .d_wr(bDWr), .d_addr(bDAddr), .d_wdata(bDWdata),
      .d_done(bDDone), .d_rdata(bDRdata),
      .mem_rd(bMemRd), .mem_wr(bMemWr), .mem_addr(bMemAddr), .mem_wdata(bMemWdata),
      .mem_rdata(bMemRdata), .busy(bBusy), .owner(bOwner)
   );

   always #5 clk = ~clk;

   // Memory models: read data is driven only during the cycle MEM_LAT after mem_rd.
   int          pendA = 0;
   bit          armA = 1'b0;
   logic [15:0] dataA = '0;
   always @(negedge clk) begin
      if (pendA > 0) pendA--;
      if (armA && pendA == 0) begin
         memRdata = dataA;
         armA = 1'b0;
      end else begin
         memRdata = 16'hDEAD;
      end
      if (memRd) begin
         pendA = 4;
         armA  = 1'b1;
         dataA = memAddr ^ 16'hBEAF;
      end
   end

   int          pendB = 0;
   bit          armB = 1'b0;
   logic [15:0] dataB = '0;
   always @(negedge clk) begin
      if (pendB > 0) pendB--;
      if (armB && pendB == 0) begin
         bMemRdata = dataB;
         armB = 1'b0;
      end else begin
         bMemRdata = 16'hDEAD;
      end
      if (bMemRd) begin
         pendB = 1;
         armB  = 1'b1;
         dataB = bMemAddr ^ 16'hBEAF;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic applyStimulus(input logic ir, input logic [15:0] ia, input logic dr,
                                input logic dw, input logic [15:0] da, input logic [15:0] dwd);
      iReq   = ir;
      iAddr  = ia;
      dReq   = dr;
      dWr    = dw;
      dAddr  = da;
      dWdata = dwd;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   logic        expOwner [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

   initial begin
      // Reset held for two cycles with both requests asserted.
      applyStimulus(1'b1, 16'h0100, 1'b1, 1'b0, 16'h2000, 16'h0000);
      tick(2);
      checkOutput("rst_memRd", memRd, 0);
      checkOutput("rst_memWr", memWr, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_owner", owner, 0);
      checkOutput("rst_done", {iDone, dDone}, 0);
      checkOutput("rst_rdata", {iRdata, dRdata}, 0);
      checkOutput("rst_memAddr", memAddr, 0);
      checkOutput("rst_lat1_busy", bBusy, 0);

      // Both sides requesting continuously: grant order D,D,I,D,D,I.
      rst = 1'b1;
      for (int g = 0; g < 6; g++) begin
         tick(1);
         checkOutput($sformatf("arb%0d_memRd", g), memRd, 1);
         checkOutput($sformatf("arb%0d_memWr", g), memWr, 0);
         checkOutput($sformatf("arb%0d_owner", g), owner, expOwner[g]);
         checkOutput($sformatf("arb%0d_addr", g), memAddr,
                     expOwner[g] ? 32'h2000 : 32'h0100);
         checkOutput($sformatf("arb%0d_busy", g), busy, 1);
         tick(1);
         checkOutput($sformatf("arb%0d_rdPulse", g), memRd, 0);
         tick(4);
         checkOutput($sformatf("arb%0d_iDone", g), iDone, !expOwner[g]);
         checkOutput($sformatf("arb%0d_dDone", g), dDone, expOwner[g]);
         if (expOwner[g]) begin
            checkOutput($sformatf("arb%0d_dRdata", g), dRdata, 16'h9EAF);
         end else begin
            checkOutput($sformatf("arb%0d_iRdata", g), iRdata, 16'hBFAF);
         end
         if (g == 0) checkOutput("arb0_iRdataUntouched", iRdata, 0);
         if (g == 5) applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
         tick(1);
         checkOutput($sformatf("arb%0d_idleBusy", g), busy, 0);
         checkOutput($sformatf("arb%0d_donePulse", g), {iDone, dDone}, 0);
      end
      tick(1);
      checkOutput("quiet_busy", busy, 0);
      checkOutput("quiet_memRd", memRd, 0);

      // Single I read of 0x0040.
      applyStimulus(1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000, 16'h0000);
      tick(1);
      checkOutput("iRd_memRd", memRd, 1);
      checkOutput("iRd_addr", memAddr, 16'h0040);
      checkOutput("iRd_owner", owner, 0);
      tick(1);
      checkOutput("iRd_rdOnce", memRd, 0);
      checkOutput("iRd_busy", busy, 1);
      tick(3);
      checkOutput("iRd_early", iDone, 0);
      tick(1);
      checkOutput("iRd_done", iDone, 1);
      checkOutput("iRd_data", iRdata, 16'hBEEF);
      checkOutput("iRd_dKept", dRdata, 16'h9EAF);
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
      tick(1);
      checkOutput("iRd_pulse", iDone, 0);

      // D write of 0x1234 to 0x1000.
      applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1, 16'h1000, 16'h1234);
      tick(1);
      checkOutput("dWr_memWr", memWr, 1);
      checkOutput("dWr_memRd", memRd, 0);
      checkOutput("dWr_wdata", memWdata, 16'h1234);
      checkOutput("dWr_addr", memAddr, 16'h1000);
      checkOutput("dWr_owner", owner, 1);
      tick(1);
      checkOutput("dWr_wrOnce", memWr, 0);
      checkOutput("dWr_wdataHeld", memWdata, 16'h1234);
      tick(4);
      checkOutput("dWr_done", dDone, 1);
      checkOutput("dWr_dRdataKept", dRdata, 16'h9EAF);
      checkOutput("dWr_iRdataKept", iRdata, 16'hBEEF);
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
      tick(1);
      checkOutput("dWr_pulse", dDone, 0);

      // Reset during WAIT of a D read, then replay with d_req still high.
      applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 16'h3000, 16'h0000);
      tick(1);
      checkOutput("abort_memRd", memRd, 1);
      tick(2);
      checkOutput("abort_busyWait", busy, 1);
      rst = 1'b0;
      tick(1);
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_noDone", dDone, 0);
      checkOutput("abort_rdata", {iRdata, dRdata}, 0);
      checkOutput("abort_memAddr", memAddr, 0);
      rst = 1'b1;
      tick(1);
      checkOutput("replay_memRd", memRd, 1);
      checkOutput("replay_addr", memAddr, 16'h3000);
      tick(4);
      checkOutput("replay_early", dDone, 0);
      tick(1);
      checkOutput("replay_done", dDone, 1);
      checkOutput("replay_data", dRdata, 16'h8EAF);
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
      tick(1);

      // MEM_LAT=1 instance: I read completes three cycles after sampling.
      bIReq  = 1'b1;
      bIAddr = 16'h0040;
      tick(1);
      checkOutput("lat1_memRd", bMemRd, 1);
      checkOutput("lat1_addr", bMemAddr, 16'h0040);
      tick(1);
      checkOutput("lat1_rdOnce", bMemRd, 0);
      checkOutput("lat1_early", bIDone, 0);
      checkOutput("lat1_busy", bBusy, 1);
      tick(1);
      checkOutput("lat1_done", bIDone, 1);
      checkOutput("lat1_data", bIRdata, 16'hBEEF);
      bIReq = 1'b0;
      tick(1);
      checkOutput("lat1_pulse", bIDone, 0);
      checkOutput("lat1_idle", bBusy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
